// File: rtl/mem64_read_arbiter_pkg.sv
// Shared constants and types for the mem64 read arbiter: ROM geometry, FSM states
// and the (valid, owner, last) tag carried alongside each issued ROM address.
package mem64_arb_pkg;

    localparam int DEPTH   = 64;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int DATA_W  = 5;
    localparam int OWNER_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
        logic               last;
    } rd_tag_t;

endpackage

// File: rtl/mem64_read_arbiter_rr_arbiter.sv
// Round-robin grant selection with a pointer register holding the last winner.
// With MEM64_ARB_PRIO0_EN defined, requester 0 always wins and 1..N_REQ-1 rotate.
module rr_arbiter #(
    parameter  int N_REQ = 3,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             update,
    output logic             anyReq,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grantIdx
);

    logic [IDX_W-1:0] ptr;
    logic             found;
    int               idx;

    always_comb begin
        anyReq   = |req;
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        idx      = 0;
`ifdef MEM64_ARB_PRIO0_EN
        if (req[0]) begin
            found = 1'b1;
        end
        // Pointer stays within 1..N_REQ-1, so the search rotates over those only.
        for (int k = 1; k < N_REQ; k++) begin
            idx = ((int'(ptr) - 1 + k) % (N_REQ - 1)) + 1;
            if (!found && req[IDX_W'(idx)]) begin
                found    = 1'b1;
                grantIdx = IDX_W'(idx);
            end
        end
`else
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[IDX_W'(idx)]) begin
                found    = 1'b1;
                grantIdx = IDX_W'(idx);
            end
        end
`endif
        if (found) begin
            grant[grantIdx] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr <= IDX_W'(N_REQ - 1);
`ifdef MEM64_ARB_PRIO0_EN
        end else if (update && anyReq && (grantIdx != '0)) begin
`else
        end else if (update && anyReq) begin
`endif
            ptr <= grantIdx;
        end
    end

endmodule

// File: rtl/mem64_read_arbiter.sv
// Shares the mem64 ROM read port among N_REQ burst requesters; returned data is
// steered by a MEM_LAT-deep tag pipeline. Optional build macro: MEM64_ARB_PRIO0_EN.
module mem64_read_arbiter
    import mem64_arb_pkg::*;
#(
    parameter  int N_REQ   = 3,
    parameter  int MEM_LAT = 1,
    localparam int IDX_W   = $clog2(N_REQ)
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [N_REQ-1:0][ADDR_W-1:0]   req_len,
    output logic [N_REQ-1:0]               ack,
    output logic [N_REQ-1:0]               rd_valid,
    output logic [DATA_W-1:0]              rd_data,
    output logic                           rd_last,
    output logic                           busy,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic [DATA_W-1:0]              mem_data
);

    arb_state_t       state;
    logic [ADDR_W-1:0] cnt;
    logic [IDX_W-1:0]  owner;
    logic              arbUpdate;
    logic              anyReq;
    logic [N_REQ-1:0]  grant;
    logic [IDX_W-1:0]  grantIdx;
    rd_tag_t           tagIn;
    rd_tag_t           tagOut;
    rd_tag_t           tag_p [MEM_LAT];

    assign arbUpdate = (state == IDLE);

    rr_arbiter #(.N_REQ(N_REQ)) uArb (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .update   (arbUpdate),
        .anyReq   (anyReq),
        .grant    (grant),
        .grantIdx (grantIdx)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            ack      <= '0;
            mem_addr <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        mem_addr <= req_addr[grantIdx];
                        cnt      <= req_len[grantIdx];
                        owner    <= grantIdx;
                        ack      <= grant;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    // The address of the final beat is held; nothing further is issued.
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        cnt      <= cnt - ADDR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Issue stage: one tag per cycle in which mem_addr holds a burst address.
    assign tagIn = '{valid: (state == BURST), owner: OWNER_W'(owner), last: (cnt == '0)};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_p[i] <= '0;
            end
        end else begin
            tag_p[0] <= tagIn;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    // Return stage: the oldest tag lines up with mem_data.
    assign tagOut  = tag_p[MEM_LAT-1];
    assign rd_data = mem_data;
    assign rd_last = tagOut.valid && tagOut.last;

    always_comb begin
        rd_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rd_valid[i] = tagOut.valid && (tagOut.owner == OWNER_W'(i));
        end
    end

    always_comb begin
        busy = (state == BURST);
        for (int i = 0; i < MEM_LAT; i++) begin
            busy = busy | tag_p[i].valid;
        end
    end

endmodule

// File: tb/tb_mem64_read_arbiter.sv
// Scoreboard bench for mem64_read_arbiter with a behavioural one-cycle ROM.
// Honours MEM64_ARB_PRIO0_EN for the expected grant order.
module tb_mem64_read_arbiter;

    localparam int N = 3;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N-1:0][5:0] req_addr = '0;
    logic [N-1:0][5:0] req_len = '0;
    logic [N-1:0]      ack;
    logic [N-1:0]      rd_valid;
    logic [4:0]        rd_data;
    logic              rd_last;
    logic              busy;
    logic [5:0]        mem_addr;
    logic [4:0]        romData = '0;

    typedef struct {
        int owner;
        int data;
        bit last;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    cycleCnt = 0;
    int    ackQ[$];
    beat_t beatQ[$];
    int    expOwner;
    beat_t expBeat;

    mem64_read_arbiter #(.N_REQ(N), .MEM_LAT(1)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .req_addr (req_addr),
        .req_len  (req_len),
        .ack      (ack),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .busy     (busy),
        .mem_addr (mem_addr),
        .mem_data (romData)
    );

    always #5 clock = ~clock;

    function automatic logic [4:0] romImg(input int a);
        return 5'((a * 13 + 7) % 32);
    endfunction

    always @(posedge clock) begin
        romData  <= romImg(int'(mem_addr));
        cycleCnt <= cycleCnt + 1;
    end

    // Monitor: every ack and every returned beat is matched against the queues.
    always @(negedge clock) begin
        if (ack != '0) begin
            checks++;
            if (ackQ.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected got %b required none", ack);
            end else begin
                expOwner = ackQ.pop_front();
                if (ack !== (3'b001 << expOwner)) begin
                    errors++;
                    $display("FAIL ack_onehot got %b required %b", ack, 3'b001 << expOwner);
                end
            end
        end
        if (rd_valid != '0) begin
            checks++;
            if (beatQ.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected got valid=%b data=%0d", rd_valid, rd_data);
            end else begin
                expBeat = beatQ.pop_front();
                if (rd_valid !== (3'b001 << expBeat.owner) || rd_data !== 5'(expBeat.data) ||
                    rd_last !== expBeat.last) begin
                    errors++;
                    $display("FAIL beat got valid=%b data=%0d last=%b required valid=%b data=%0d last=%b",
                             rd_valid, rd_data, rd_last, 3'b001 << expBeat.owner, expBeat.data, expBeat.last);
                end
            end
        end else if (rd_last !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL rd_last_idle got %b required 0", rd_last);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic expectBurst(input int who, input int addr, input int len);
        ackQ.push_back(who);
        for (int i = 0; i <= len; i++) begin
            beatQ.push_back('{who, int'(romImg((addr + i) % 64)), (i == len)});
        end
    endtask

    task automatic waitAck(output int who);
        who = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (ack != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (ack[i]) who = i;
                end
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL ack_timeout got none required an ack");
    endtask

    task automatic waitIdle();
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (!busy) break;
        end
        check("busy_clear", int'(busy), 0);
    endtask

    initial begin
        int who;
        int prevCyc;
        int seq[4];
        int a3[3];
        int firstNew;
        int secondNew;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_ack", int'(ack), 0);
        check("rst_rd_valid", int'(rd_valid), 0);
        check("rst_rd_last", int'(rd_last), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Single one-word request from requester 1
        req_addr[1] = 6'd5;
        req_len[1]  = 6'd0;
        expectBurst(1, 5, 0);
        req = 3'b010;
        waitAck(who);
        req = '0;
        check("t1_grant", who, 1);
        check("t1_mem_addr", int'(mem_addr), 5);
        check("t1_busy_c", int'(busy), 1);
        @(negedge clock);
        check("t1_busy_c1", int'(busy), 1);
        @(negedge clock);
        check("t1_busy_c2", int'(busy), 0);

        // Address wrap 62,63,0,1
        req_addr[0] = 6'd62;
        req_len[0]  = 6'd3;
        expectBurst(0, 62, 3);
        req = 3'b001;
        waitAck(who);
        req = '0;
        check("t2_grant", who, 0);
        check("t2_addr0", int'(mem_addr), 62);
        for (int i = 1; i < 4; i++) begin
            @(negedge clock);
            check("t2_addr", int'(mem_addr), (62 + i) % 64);
        end
        @(negedge clock);
        check("t2_addr_hold", int'(mem_addr), 1);
        waitIdle();

        // Contention from a fresh reset
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        a3 = '{10, 20, 30};
`ifdef MEM64_ARB_PRIO0_EN
        seq = '{0, 0, 0, 0};
`else
        seq = '{0, 1, 2, 0};
`endif
        for (int i = 0; i < N; i++) begin
            req_addr[i] = 6'(a3[i]);
            req_len[i]  = 6'd1;
        end
        for (int i = 0; i < 4; i++) begin
            expectBurst(seq[i], a3[seq[i]], 1);
        end
        req = 3'b111;
        prevCyc = 0;
        for (int i = 0; i < 4; i++) begin
            waitAck(who);
            if (i == 3) req = '0;
            check("t3_grant", who, seq[i]);
            if (i > 0) check("t3_gap", cycleCnt - prevCyc, 3);
            prevCyc = cycleCnt;
        end
        waitIdle();

        // Full 64-word sweep
        req_addr[2] = 6'd0;
        req_len[2]  = 6'd63;
        expectBurst(2, 0, 63);
        req = 3'b100;
        waitAck(who);
        req = '0;
        check("t4_grant", who, 2);
        waitIdle();

        // Reset during beat 10 of a 21-word burst
        req_addr[1] = 6'd0;
        req_len[1]  = 6'd20;
        ackQ.push_back(1);
        for (int i = 0; i < 10; i++) begin
            beatQ.push_back('{1, int'(romImg(i)), 1'b0});
        end
        req = 3'b010;
        waitAck(who);
        req = '0;
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("t5_ack", int'(ack), 0);
        check("t5_rd_valid", int'(rd_valid), 0);
        check("t5_rd_last", int'(rd_last), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_mem_addr", int'(mem_addr), 0);
        req_addr[1] = 6'd7;
        req_len[1]  = 6'd0;
        req_addr[2] = 6'd9;
        req_len[2]  = 6'd0;
        expectBurst(1, 7, 0);
        expectBurst(2, 9, 0);
        req = 3'b110;
        waitAck(who);
        check("t5_first_grant", who, 1);
        req[1] = 1'b0;
        waitAck(who);
        check("t5_second_grant", who, 2);
        req[2] = 1'b0;
        waitIdle();

        // Requester 0 rises one cycle before the current burst ends
        req_addr[1] = 6'd40;
        req_len[1]  = 6'd3;
        req_addr[2] = 6'd50;
        req_len[2]  = 6'd0;
        req_addr[0] = 6'd1;
        req_len[0]  = 6'd0;
        expectBurst(1, 40, 3);
        req = 3'b110;
        waitAck(who);
        req[1] = 1'b0;
        check("t6_first_grant", who, 1);
        prevCyc = cycleCnt;
        @(negedge clock);
        @(negedge clock);
        req[0] = 1'b1;
`ifdef MEM64_ARB_PRIO0_EN
        firstNew  = 0;
        secondNew = 2;
        expectBurst(0, 1, 0);
        expectBurst(2, 50, 0);
`else
        firstNew  = 2;
        secondNew = 0;
        expectBurst(2, 50, 0);
        expectBurst(0, 1, 0);
`endif
        waitAck(who);
        if (who >= 0) req[who] = 1'b0;
        check("t6_next_grant", who, firstNew);
        check("t6_gap", cycleCnt - prevCyc, 5);
        waitAck(who);
        if (who >= 0) req[who] = 1'b0;
        check("t6_last_grant", who, secondNew);
        waitIdle();

        repeat (3) @(negedge clock);
        check("ackQ_empty", ackQ.size(), 0);
        check("beatQ_empty", beatQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem64_read_arbiter.md
Name: mem64_read_arbiter

Overview:
- Shares the single read port of the 64x5 mem64 ROM among N requesters, e.g. VGA pixel fetch, sprite fetch and debug reader.
- Accepts burst read requests of 1-64 words and arbitrates between them round-robin.
- Drives the ROM address register and routes returned data to the granted requester, accounting for the ROM read latency.
- Sits between the VGA fetch logic and mem64; mem_addr connects to rAddr and mem_data connects to dataOut.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- MEM_LAT, 1, clock edges from mem_addr being sampled by mem64 to dataOut valid (1..3).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous reset, active low.
- req  in  N_REQ  per-requester request; held high until ack.
- req_addr  in  N_REQ x 6  start address per requester.
- req_len  in  N_REQ x 6  burst length minus 1 (0 = 1 word, 63 = 64 words).
- ack  out  N_REQ  one-cycle pulse: request accepted.
- rd_valid  out  N_REQ  one-hot: rd_data belongs to this requester this cycle.
- rd_data  out  5  read data (mem_data passed through).
- rd_last  out  1  high with the final beat of a burst.
- busy  out  1  high in BURST or while any beat is in flight.
- mem_addr  out  6  registered ROM address (to rAddr).
- mem_data  in  5  ROM data (from dataOut).

Behaviour:
- Reset values (reset_n low at an edge): ack=0, rd_valid=0, rd_last=0, busy=0, mem_addr=0, state=IDLE.
  - In-flight pipeline cleared; those beats are never delivered.
  - Round-robin pointer set to N_REQ-1, so requester 0 has first priority.
- States: IDLE, BURST.
- IDLE: if any req bit is high at an edge, select the winner i round-robin, searching upward from pointer+1 with wrap.
  - At that edge: mem_addr <= req_addr[i], cnt <= req_len[i], owner <= i, pointer <= i, ack[i] <= 1, state <= BURST.
- BURST: at each edge, mem_addr <= mem_addr+1 mod 64 (63 wraps to 0) and cnt <= cnt-1.
  - When cnt==0 at an edge, no further address is issued and state <= IDLE.
  - Issue count is exactly req_len+1 addresses on consecutive cycles.
- ack is high only in the cycle immediately after the grant edge.
- A requester drops req in the ack cycle. If req is still high when IDLE is next evaluated, it is treated as a new request.
- A req dropped before ack is withdrawn with no side effects.
- Data return: a (valid, owner, last) tag is pushed each issue cycle and delayed through a MEM_LAT-deep shift register.
  - rd_valid[owner] is high in the cycle mem_data corresponds to that address.
  - For MEM_LAT=1: ack in cycle c, first beat in cycle c+1, last beat in cycle c+1+req_len.
- rd_data = mem_data, combinational. Its value is don't-care when rd_valid is all zero.
- Minimum gap between bursts: one IDLE cycle between the last address of one burst and the first address of the next.
  - In-flight data of the previous burst still delivers during and after that gap.
- Only one owner at a time. New requests never pre-empt a burst.
- busy = (state==BURST) OR any valid tag in the pipeline.

Optional Feature:
- Macro MEM64_ARB_PRIO0_EN.
- Defined: requester 0 wins every IDLE arbitration in which req[0] is high. Requesters 1..N_REQ-1 round-robin among themselves, and the pointer updates only on their grants.
- Undefined: pure round-robin across all N_REQ requesters.
- Ports and timing are identical in both builds.

Decomposition:
- Package mem64_arb_pkg holds:
  - Constants ADDR_W=6, DATA_W=5, DEPTH=64.
  - typedef arb_state_t {IDLE, BURST}.
  - typedef rd_tag_t {valid, owner, last}.
- Sub-module rr_arbiter holds the request vector, pointer register and grant logic, plus the PRIO0 variant under the macro.
- Top-level mem64_read_arbiter holds the FSM, address counter and tag pipeline.

Test Plan (instantiate mem64; compare rd_data to the ROM image):
- Single request, req[1]=1, addr=5, len=0 -> ack[1] in cycle c, one beat in c+1 with rd_valid=3'b010, rd_last=1, rd_data=ROM[5]; busy clears in c+2.
- Wrap burst, req[0], addr=62, len=3 -> mem_addr sequence 62,63,0,1; four beats of ROM[62],ROM[63],ROM[0],ROM[1]; rd_last on the 4th beat.
- Contention, req=3'b111 held after reset, each len=1 -> grant order 0,1,2,0; ack one-hot each time; one IDLE cycle between bursts.
- Full sweep, req[2], addr=0, len=63 -> 64 consecutive beats matching ROM[0..63]; rd_last only on beat 64.
- Reset mid-burst: assert reset_n=0 for one edge during beat 10 of a len=20 burst -> next cycle all outputs 0, state IDLE, no further rd_valid; a fresh request afterwards is granted to the lowest active requester.
- PRIO0 build: req=3'b110 active, req[0] rising one cycle before the current burst ends -> next grant goes to 0. Non-PRIO0 build with the same stimulus -> next grant follows the round-robin pointer.
